// File: rtl/dest_track_pkg.sv
// Shared definitions for the destination-register tracker: opcode constants,
// the pipeline stage entry and a small helper for counting live writers.
package dest_track_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // Widest register address a stage entry can carry; the top uses the low REG_AW bits.
  localparam int unsigned WREG_W = 8;

  typedef struct packed {
    logic              valid;
    logic [WREG_W-1:0] wreg;
    logic              reg_write;
    logic              mem_read;
  } stage_t;

  function automatic logic [1:0] writer_cnt(input stage_t s);
    return {1'b0, s.valid & s.reg_write};
  endfunction

endpackage

// File: rtl/dest_track_dest_decode.sv
// Destination-register decode for one instruction: rd for R-type, the link
// register for jal, rt for everything else.
module dest_decode
  import dest_track_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic [5:0]        opcode_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  output logic [REG_AW-1:0] wreg_o
);

  always_comb begin
    unique case (opcode_i)
      OP_RTYPE: wreg_o = REG_AW'(rd_i);
      OP_JAL:   wreg_o = REG_AW'(LINK_REG);
      default:  wreg_o = REG_AW'(rt_i);
    endcase
  end

endmodule

// File: rtl/dest_track.sv
// Tracks destination registers through ID/EX, EX/MEM and MEM/WB and raises the
// load-use stall. Define BRANCH_HAZARD_EN to also stall beq/bne on pending writers.
module dest_track
  import dest_track_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_instru,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [REG_AW-1:0] ex_mem_wreg,
  output logic              ex_mem_reg_write,
  output logic [REG_AW-1:0] mem_wb_wreg,
  output logic              mem_wb_reg_write,
  output logic              stall,
  output logic [1:0]        inflight
);

  stage_t            id_ex_q, ex_mem_q, mem_wb_q;
  stage_t            id_entry, id_ex_d;
  logic [1:0]        inflight_q, inflight_d;
  logic [REG_AW-1:0] dec_wreg, rs, rt;
  logic              idex_hit, load_use;

  assign rs = REG_AW'(id_instru[25:21]);
  assign rt = REG_AW'(id_instru[20:16]);

  dest_decode #(
    .REG_AW  (REG_AW),
    .LINK_REG(LINK_REG)
  ) u_dest_decode (
    .opcode_i(id_instru[31:26]),
    .rt_i    (id_instru[20:16]),
    .rd_i    (id_instru[15:11]),
    .wreg_o  (dec_wreg)
  );

  assign idex_hit = (id_ex_q.wreg[REG_AW-1:0] == rs) || (id_ex_q.wreg[REG_AW-1:0] == rt);
  assign load_use = id_valid & id_ex_q.mem_read & id_ex_q.reg_write & idex_hit;

`ifdef BRANCH_HAZARD_EN
  logic is_branch, exmem_hit, branch_hazard;

  assign is_branch = (id_instru[31:26] == OP_BEQ) || (id_instru[31:26] == OP_BNE);
  assign exmem_hit = (ex_mem_q.wreg[REG_AW-1:0] == rs) || (ex_mem_q.wreg[REG_AW-1:0] == rt);
  assign branch_hazard = id_valid & is_branch &
                         ((id_ex_q.valid & id_ex_q.reg_write & idex_hit) |
                          (ex_mem_q.mem_read & ex_mem_q.reg_write & exmem_hit));
  assign stall = load_use | branch_hazard;
`else
  assign stall = load_use;
`endif

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = 1'b1;
    id_entry.wreg      = WREG_W'(dec_wreg);
    id_entry.reg_write = id_reg_write & (dec_wreg != '0);
    id_entry.mem_read  = id_mem_read;
    // Flush wins over stall: either way a bubble enters and the killed instruction is dropped.
    id_ex_d    = (stall | flush | ~id_valid) ? '0 : id_entry;
    inflight_d = writer_cnt(id_ex_d) + writer_cnt(id_ex_q) + writer_cnt(ex_mem_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q    <= '0;
      ex_mem_q   <= '0;
      mem_wb_q   <= '0;
      inflight_q <= '0;
    end else begin
      id_ex_q    <= id_ex_d;
      ex_mem_q   <= id_ex_q;
      mem_wb_q   <= ex_mem_q;
      inflight_q <= inflight_d;
    end
  end

  assign ex_mem_wreg      = ex_mem_q.wreg[REG_AW-1:0];
  assign ex_mem_reg_write = ex_mem_q.reg_write;
  assign mem_wb_wreg      = mem_wb_q.wreg[REG_AW-1:0];
  assign mem_wb_reg_write = mem_wb_q.reg_write;
  assign inflight         = inflight_q;

  // Fields and instruction bits that are carried but not needed on any output.
  logic unused_bits;
  assign unused_bits = ^{id_instru[10:0], id_ex_q, ex_mem_q, mem_wb_q};

endmodule
